// File: rtl/ahb_arbiter.sv
// ahb_arbiter: five-master AHB address/control bus arbiter.
//   Latency: HGRANT updates on the HREADY=1 edge that samples the request
//   (1 cycle); HMASTER/HMASTLOCK follow HGRANT on the next HREADY=1 edge.
//   Backpressure: HREADY=0 freezes every piece of state (grant, owner, FSM, beats).
// Ports:
//   CLK, RESET          bus clock; asynchronous active-high reset
//   HBUSREQ[4:0]        per-master bus request
//   HLOCK[4:0]          per-master locked-sequence request
//   HREADY              address phase accepted this cycle
//   HTRANS[1:0]         address-phase transfer type of the current owner
//   HBURST[2:0]         address-phase burst type of the current owner
//   HGRANT[4:0]         one-hot grant (registered)
//   HMASTER[3:0]        owner of the current address phase (registered)
//   HMASTLOCK           current address phase is locked (registered)
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority (master 0
// highest); otherwise round-robin starting after the last winner.
module ahb_arbiter #(
  parameter int DEFAULT_MASTER = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [4:0] HBUSREQ,
  input  logic [4:0] HLOCK,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  output logic [4:0] HGRANT,
  output logic [3:0] HMASTER,
  output logic       HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] DEF_IDX   = 3'(DEFAULT_MASTER);
  localparam logic [4:0] DEF_GRANT = 5'd1 << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] grant_q, grant_d;
  logic [3:0] hmaster_q;
  logic       hmastlock_q;

  logic [2:0] owner;      // index of the currently granted master
  logic [2:0] sel;        // arbitration choice ignoring lock
  logic [2:0] winner;     // arbitration choice including lock hold
  logic [3:0] beats_m1;   // fixed-burst length minus one, 0 if not fixed
  logic       fixed_burst;
  logic       arb_ok;

  // One-hot grant to index.
  always_comb begin
    owner = DEF_IDX;
    for (int i = 0; i < 5; i++) begin
      if (grant_q[i]) owner = 3'(i);
    end
  end

  // Fixed-length burst decode; HBURST[0] (wrap vs incr) does not affect length.
  always_comb begin
    beats_m1 = 4'd0;
    case (HBURST)
      3'b010, 3'b011: beats_m1 = 4'd3;
      3'b100, 3'b101: beats_m1 = 4'd7;
      3'b110, 3'b111: beats_m1 = 4'd15;
      default:        beats_m1 = 4'd0;
    endcase
  end
  assign fixed_burst = (beats_m1 != 4'd0);

`ifdef ARB_FIXED_PRIORITY_EN
  // Lowest requesting index wins.
  always_comb begin
    logic found;
    sel   = DEF_IDX;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!found && HBUSREQ[i]) begin
        sel   = 3'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [2:0] last_q, last_d;

  // Search upward from the master after the last winner, wrapping at 5.
  always_comb begin
    logic found;
    int   j;
    sel   = DEF_IDX;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= 5; k++) begin
      j = (int'(last_q) + k) % 5;
      if (!found && HBUSREQ[j]) begin
        sel   = 3'(j);
        found = 1'b1;
      end
    end
  end
`endif

  // A granted master holding HLOCK keeps the bus over any round-robin choice.
  assign winner = HLOCK[owner] ? owner : sel;

  // BURST allows handover only while the final beat's address is accepted.
  assign arb_ok = (state_q == ST_ARB) ||
                  ((state_q == ST_BURST) && (cnt_q == 4'd1) && (HTRANS == TR_SEQ));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
`ifndef ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    if (HREADY) begin
      case (state_q)
        ST_ARB: begin
          if ((HTRANS == TR_NONSEQ) && fixed_burst) begin
            state_d = ST_BURST;
            cnt_d   = beats_m1;
          end
        end
        ST_BURST: begin
          case (HTRANS)
            TR_SEQ: begin
              cnt_d = cnt_q - 4'd1;
              if (cnt_q == 4'd1) state_d = ST_ARB;
            end
            TR_NONSEQ: begin
              // A new fixed burst restarts the count; anything else ends it early.
              if (fixed_burst) begin
                cnt_d = beats_m1;
              end else begin
                state_d = ST_ARB;
                cnt_d   = 4'd0;
              end
            end
            TR_IDLE: begin
              state_d = ST_ARB;
              cnt_d   = 4'd0;
            end
            default: ;  // BUSY holds the count
          endcase
        end
        ST_LOCK: begin
          if (!HLOCK[owner] && (HTRANS != TR_BUSY)) state_d = ST_ARB;
        end
        default: begin
          state_d = ST_ARB;
          cnt_d   = 4'd0;
        end
      endcase

      if (arb_ok) begin
        grant_d = 5'd1 << winner;
`ifndef ARB_FIXED_PRIORITY_EN
        last_d  = winner;
`endif
        if (HLOCK[winner]) begin
          state_d = ST_LOCK;
          cnt_d   = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_ARB;
      cnt_q       <= 4'd0;
      grant_q     <= DEF_GRANT;
      hmaster_q   <= {1'b0, DEF_IDX};
      hmastlock_q <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q      <= DEF_IDX;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
      // Address-phase owner is whoever held the grant when this phase was accepted.
      if (HREADY) begin
        hmaster_q   <= {1'b0, owner};
        hmastlock_q <= HLOCK[owner];
      end
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

endmodule
